// File: rtl/count_stream_checker_if.sv
// count_stream_checker_if
//   Sample bus between a counter generator (master) and the stream checker
//   (slave).
//   din        sampled counter value
//   din_valid  din is meaningful this cycle
interface count_stream_checker_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] din;
    logic             din_valid;

    modport master (output din, output din_valid);
    modport slave  (input  din, input  din_valid);
endinterface

// File: rtl/count_stream_checker.sv
// count_stream_checker
//   Receive-side monitor for a free-running up-counter stream. It acquires
//   lock on a strictly incrementing (mod 2^WIDTH) sequence. Once locked, it
//   pulses and counts every sample that breaks the sequence, and it drops
//   lock after LOSS_COUNT consecutive misses.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   bus        slave side of the sample bus (din, din_valid)
//   clear_err  synchronous clear of err_count
//   locked     high while in LOCKED
//   err_pulse  one-cycle pulse for each mismatching valid sample in LOCKED
//   err_count  saturating mismatch count
//   expected   next value predicted in LOCKED; holds its value otherwise
//
// state   | meaning
// --------+------------------------------------------------------------
// ACQUIRE | looking for LOCK_COUNT consecutive +1 steps; no errors counted
// LOCKED  | comparing against the flywheel prediction; counting misses
module count_stream_checker #(
    parameter int WIDTH      = 8,
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3,
    parameter int ERR_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    count_stream_checker_if.slave  bus,
    input  logic                   clear_err,
    output logic                   locked,
    output logic                   err_pulse,
    output logic [ERR_W-1:0]       err_count,
    output logic [WIDTH-1:0]       expected
);

    localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W = $clog2(LOSS_COUNT + 1);
    localparam logic [RUN_W-1:0]  LOCK_N  = RUN_W'(LOCK_COUNT);
    localparam logic [MISS_W-1:0] LOSS_N  = MISS_W'(LOSS_COUNT);
    localparam logic [ERR_W-1:0]  ERR_MAX = '1;

    typedef enum logic {ACQUIRE, LOCKED} state_t;

    state_t              state;
    logic [WIDTH-1:0]    prev;
    logic                have_prev;
    logic [RUN_W-1:0]    run;
    logic [MISS_W-1:0]   miss;

    logic [WIDTH-1:0]    din_inc;
    logic [WIDTH-1:0]    prev_inc;
    logic [WIDTH-1:0]    exp_inc;
    logic [RUN_W-1:0]    run_inc;
    logic [MISS_W-1:0]   miss_inc;
    logic                mismatch;
    logic                err_event;
    logic [ERR_W-1:0]    err_next;

    always_comb begin
        din_inc   = bus.din + 1'b1;
        prev_inc  = prev + 1'b1;
        exp_inc   = expected + 1'b1;
        run_inc   = run + 1'b1;
        miss_inc  = miss + 1'b1;
        mismatch  = (bus.din != expected);
        err_event = bus.din_valid && (state == LOCKED) && mismatch;
    end

    // A clear that coincides with a new error keeps that error in the count.
    always_comb begin
        err_next = err_count;
        if (clear_err)
            err_next = err_event ? ERR_W'(1) : '0;
        else if (err_event && (err_count != ERR_MAX))
            err_next = err_count + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACQUIRE;
            locked    <= 1'b0;
            prev      <= '0;
            have_prev <= 1'b0;
            run       <= '0;
            miss      <= '0;
            expected  <= '0;
            err_count <= '0;
            err_pulse <= 1'b0;
        end else begin
            err_count <= err_next;
            err_pulse <= err_event;
            if (bus.din_valid) begin
                case (state)
                    ACQUIRE: begin
                        prev      <= bus.din;
                        have_prev <= 1'b1;
                        if (have_prev && (bus.din == prev_inc)) begin
                            if (run_inc == LOCK_N) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                expected <= din_inc;
                                miss     <= '0;
                                run      <= '0;
                            end else begin
                                run <= run_inc;
                            end
                        end else begin
                            run <= '0;
                        end
                    end
                    LOCKED: begin
                        // On a miss the prediction keeps advancing so a single
                        // corrupted sample does not desynchronise the checker.
                        expected <= exp_inc;
                        if (!mismatch) begin
                            miss <= '0;
                        end else if (miss_inc == LOSS_N) begin
                            state     <= ACQUIRE;
                            locked    <= 1'b0;
                            prev      <= bus.din;
                            have_prev <= 1'b1;
                            run       <= '0;
                            miss      <= '0;
                        end else begin
                            miss <= miss_inc;
                        end
                    end
                    default: begin
                        state  <= ACQUIRE;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_count_stream_checker.sv
// tb_count_stream_checker
//   Directed scenarios plus a randomized stream, both checked against a
//   behavioural model. A second instance with a 4-bit error counter makes
//   saturation reachable in a short run.
module tb_count_stream_checker;

    localparam int LOCK_N = 4;
    localparam int LOSS_N = 3;
    localparam int BIG_MAX = 65535;
    localparam int SML_MAX = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear_err = 1'b0;
    logic        locked, err_pulse;
    logic [15:0] err_count;
    logic [7:0]  expected;
    logic        s_locked, s_err_pulse;
    logic [3:0]  s_err_count;
    logic [7:0]  s_expected;

    int total = 0;
    int bad = 0;

    count_stream_checker_if #(.WIDTH(8)) bus ();

    count_stream_checker dut (
        .clk(clk), .rst(rst), .bus(bus), .clear_err(clear_err),
        .locked(locked), .err_pulse(err_pulse),
        .err_count(err_count), .expected(expected)
    );

    count_stream_checker #(.ERR_W(4)) dut_sat (
        .clk(clk), .rst(rst), .bus(bus), .clear_err(clear_err),
        .locked(s_locked), .err_pulse(s_err_pulse),
        .err_count(s_err_count), .expected(s_expected)
    );

    always #5 clk = ~clk;

    // Behavioural reference.
    bit       m_locked, m_have, m_pulse;
    int       m_run, m_miss, m_err, m_err_s;
    logic [7:0] m_prev, m_exp;

    task automatic model_reset();
        m_locked = 0; m_have = 0; m_pulse = 0;
        m_run = 0; m_miss = 0; m_err = 0; m_err_s = 0;
        m_prev = 8'h00; m_exp = 8'h00;
    endtask

    task automatic model_step(input logic [7:0] d, input bit v, input bit c);
        bit err;
        logic [7:0] nxt;
        err = 0;
        if (v) begin
            if (!m_locked) begin
                nxt = m_prev + 8'd1;
                if (m_have && d == nxt) begin
                    m_run = m_run + 1;
                    if (m_run == LOCK_N) begin
                        m_locked = 1; m_exp = d + 8'd1; m_miss = 0; m_run = 0;
                    end
                end else begin
                    m_run = 0;
                end
                m_prev = d; m_have = 1;
            end else if (d == m_exp) begin
                m_exp = d + 8'd1; m_miss = 0;
            end else begin
                err = 1;
                m_exp = m_exp + 8'd1;
                m_miss = m_miss + 1;
                if (m_miss == LOSS_N) begin
                    m_locked = 0; m_prev = d; m_have = 1; m_run = 0; m_miss = 0;
                end
            end
        end
        m_pulse = err;
        if (c) begin
            m_err   = err ? 1 : 0;
            m_err_s = err ? 1 : 0;
        end else if (err) begin
            if (m_err < BIG_MAX) m_err = m_err + 1;
            if (m_err_s < SML_MAX) m_err_s = m_err_s + 1;
        end
    endtask

    // Apply one cycle of stimulus, then sample 1 time unit after the edge.
    task automatic drive(input logic [7:0] d, input bit v, input bit c);
        @(negedge clk);
        bus.din = d; bus.din_valid = v; clear_err = c;
        @(posedge clk);
        model_step(d, v, c);
        #1;
    endtask

    task automatic test_reset();
        bus.din = 8'h00; bus.din_valid = 1'b0; clear_err = 1'b0;
        rst = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({locked, err_pulse, err_count, expected} !== 26'd0) begin
            bad++;
            $display("FAIL reset_outputs: got locked=%0b pulse=%0b err=%0d exp=%0h, want all 0",
                     locked, err_pulse, err_count, expected);
        end
        total++;
        if ({s_locked, s_err_pulse, s_err_count, s_expected} !== 14'd0) begin
            bad++;
            $display("FAIL reset_outputs_sat: got locked=%0b pulse=%0b err=%0d exp=%0h, want all 0",
                     s_locked, s_err_pulse, s_err_count, s_expected);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_clean_lock();
        for (int i = 1; i <= 6; i++) begin
            drive(8'(i), 1, 0);
            total++;
            if (locked !== (i >= 5)) begin
                bad++;
                $display("FAIL clean_lock_locked: sample %0d got %0b want %0b", i, locked, (i >= 5));
            end
            total++;
            if (err_count !== 16'd0 || err_pulse !== 1'b0) begin
                bad++;
                $display("FAIL clean_lock_err: sample %0d got err=%0d pulse=%0b want 0/0", i, err_count, err_pulse);
            end
            if (i == 5) begin
                total++;
                if (expected !== 8'h06) begin
                    bad++;
                    $display("FAIL clean_lock_expected: got %0h want 06", expected);
                end
            end
        end
    endtask

    task automatic test_wrap();
        for (int v = 7; v <= 255; v++) drive(8'(v), 1, 0);
        for (int v = 0; v <= 1; v++) begin
            drive(8'(v), 1, 0);
            total++;
            if (err_pulse !== 1'b0 || locked !== 1'b1) begin
                bad++;
                $display("FAIL wrap_step: value %0h got pulse=%0b locked=%0b want 0/1", v, err_pulse, locked);
            end
        end
        total++;
        if (expected !== 8'h02 || err_count !== 16'd0) begin
            bad++;
            $display("FAIL wrap_expected: got exp=%0h err=%0d want 02/0", expected, err_count);
        end
    endtask

    task automatic test_flywheel();
        logic [7:0] seq [3];
        bit         want_pulse [3];
        seq = '{8'h10, 8'h55, 8'h12};
        want_pulse = '{0, 1, 0};
        for (int v = 2; v <= 15; v++) drive(8'(v), 1, 0);
        for (int i = 0; i < 3; i++) begin
            drive(seq[i], 1, 0);
            total++;
            if (err_pulse !== want_pulse[i] || locked !== 1'b1) begin
                bad++;
                $display("FAIL flywheel_step: value %0h got pulse=%0b locked=%0b want %0b/1",
                         seq[i], err_pulse, locked, want_pulse[i]);
            end
        end
        total++;
        if (err_count !== 16'd1 || expected !== 8'h13) begin
            bad++;
            $display("FAIL flywheel_count: got err=%0d exp=%0h want 1/13", err_count, expected);
        end
    endtask

    task automatic test_loss_relock();
        for (int i = 0; i < 3; i++) begin
            drive(8'hAA, 1, 0);
            total++;
            if (err_pulse !== 1'b1 || locked !== (i < 2) || err_count !== 16'(2 + i)) begin
                bad++;
                $display("FAIL loss_step: miss %0d got pulse=%0b locked=%0b err=%0d want 1/%0b/%0d",
                         i, err_pulse, locked, err_count, (i < 2), 2 + i);
            end
        end
        for (int v = 8'hAB; v <= 8'hAE; v++) begin
            drive(8'(v), 1, 0);
            total++;
            if (locked !== (v == 8'hAE) || err_pulse !== 1'b0) begin
                bad++;
                $display("FAIL relock_step: value %0h got locked=%0b pulse=%0b want %0b/0",
                         v, locked, err_pulse, (v == 8'hAE));
            end
        end
        total++;
        if (expected !== 8'hAF || err_count !== 16'd4) begin
            bad++;
            $display("FAIL relock_state: got exp=%0h err=%0d want AF/4", expected, err_count);
        end
    endtask

    task automatic test_gaps();
        for (int i = 0; i < 5; i++) begin
            drive(8'h33, 0, 0);
            total++;
            if (locked !== 1'b1 || expected !== 8'hAF || err_pulse !== 1'b0) begin
                bad++;
                $display("FAIL gap_hold: got locked=%0b exp=%0h pulse=%0b want 1/AF/0", locked, expected, err_pulse);
            end
        end
        drive(8'hAF, 1, 0);
        total++;
        if (err_pulse !== 1'b0 || expected !== 8'hB0) begin
            bad++;
            $display("FAIL gap_resume: got pulse=%0b exp=%0h want 0/B0", err_pulse, expected);
        end
    endtask

    task automatic test_clear();
        drive(8'h00, 0, 1);
        total++;
        if (err_count !== 16'd0 || s_err_count !== 4'd0) begin
            bad++;
            $display("FAIL clear_alone: got err=%0d sat_err=%0d want 0/0", err_count, s_err_count);
        end
        drive(8'h00, 1, 1);
        total++;
        if (err_count !== 16'd1 || err_pulse !== 1'b1) begin
            bad++;
            $display("FAIL clear_with_error: got err=%0d pulse=%0b want 1/1", err_count, err_pulse);
        end
        drive(8'hB1, 1, 0);
    endtask

    task automatic test_saturation();
        for (int r = 0; r < 12; r++) begin
            for (int k = 0; k < 2; k++) begin
                drive(m_exp ^ 8'h80, 1, 0);
                if (r == 11 && k == 1) begin
                    total++;
                    if (s_err_count !== 4'hF || s_err_pulse !== 1'b1) begin
                        bad++;
                        $display("FAIL sat_hold: got err=%0d pulse=%0b want 15/1", s_err_count, s_err_pulse);
                    end
                end
            end
            drive(m_exp, 1, 0);
        end
        total++;
        if (err_count !== 16'd25 || locked !== 1'b1) begin
            bad++;
            $display("FAIL sat_big_count: got err=%0d locked=%0b want 25/1", err_count, locked);
        end
        drive(m_exp ^ 8'h01, 1, 1);
        total++;
        if (s_err_count !== 4'd1 || err_count !== 16'd1) begin
            bad++;
            $display("FAIL sat_clear_error: got sat_err=%0d err=%0d want 1/1", s_err_count, err_count);
        end
        drive(m_exp, 1, 0);
    endtask

    task automatic test_async_reset();
        #2 rst = 1'b1;
        #1;
        total++;
        if ({locked, err_pulse, err_count, expected} !== 26'd0) begin
            bad++;
            $display("FAIL async_reset: got locked=%0b pulse=%0b err=%0d exp=%0h, want all 0",
                     locked, err_pulse, err_count, expected);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(8'(8'h40 + i), 1, 0);
            total++;
            if (locked !== (i == 4)) begin
                bad++;
                $display("FAIL reacquire: sample %0d got locked=%0b want %0b", i + 1, locked, (i == 4));
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        bit v, c;
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 9) != 0);
            c = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 99) < 85)
                d = m_locked ? m_exp : (m_prev + 8'd1);
            else
                d = 8'($urandom);
            drive(d, v, c);
            total++;
            if (locked !== m_locked || err_pulse !== m_pulse ||
                err_count !== 16'(m_err) || expected !== m_exp) begin
                bad++;
                $display("FAIL random_main: cycle %0d got L=%0b P=%0b E=%0d X=%0h want L=%0b P=%0b E=%0d X=%0h",
                         i, locked, err_pulse, err_count, expected, m_locked, m_pulse, m_err, m_exp);
            end
            total++;
            if (s_locked !== m_locked || s_err_pulse !== m_pulse ||
                s_err_count !== 4'(m_err_s) || s_expected !== m_exp) begin
                bad++;
                $display("FAIL random_sat: cycle %0d got L=%0b P=%0b E=%0d X=%0h want L=%0b P=%0b E=%0d X=%0h",
                         i, s_locked, s_err_pulse, s_err_count, s_expected, m_locked, m_pulse, m_err_s, m_exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_wrap();
        test_flywheel();
        test_loss_relock();
        test_gaps();
        test_clear();
        test_saturation();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
